// File: rtl/topk_pkg.sv
// Shared types for the sequential top-K selector and its compare-and-swap unit.
// Holds the controller state enum and the cas control word.
package topk_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } topk_seq_state_e;

    // sign_ctrl selects signed compare, descend flips the ordering,
    // bypass passes the pair through untouched.
    typedef struct packed {
        logic sign_ctrl;
        logic descend;
        logic bypass;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/cas.sv
// Registered compare-and-swap: y1 gets the lower-ordered value, y2 the other,
// one cycle after x1/x2 are presented. Equal inputs are never swapped.
module cas
    import topk_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  ctrl_t                ctrl,
    input  logic [DATAWIDTH-1:0] x1,
    input  logic [DATAWIDTH-1:0] x2,
    output logic [DATAWIDTH-1:0] y1,
    output logic [DATAWIDTH-1:0] y2
);

    logic x1_gt;
    logic x1_lt;
    logic swap;

    // Decide ordering in the selected number format; strict compares keep ties in place
    always_comb begin
        if (ctrl.sign_ctrl) begin
            x1_gt = $signed(x1) > $signed(x2);
            x1_lt = $signed(x1) < $signed(x2);
        end else begin
            x1_gt = x1 > x2;
            x1_lt = x1 < x2;
        end
        swap = !ctrl.bypass && (ctrl.descend ? x1_lt : x1_gt);
    end

    // Register the ordered pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y1 <= '0;
            y2 <= '0;
        end else begin
            y1 <= swap ? x2 : x1;
            y2 <= swap ? x1 : x2;
        end
    end

endmodule

// File: rtl/topk_seq_ctrl.sv
// Sequential top-K selector: loads N elements, sorts them in place with
// odd-even transposition through one shared cas, then streams the K largest
// in descending order.
// Optional macro TOPK_SEQ_EARLY_EXIT_EN: stop sorting after two consecutive
// phases that moved nothing.
module topk_seq_ctrl
    import topk_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int N         = 8,
    parameter int K         = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sign_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DATAWIDTH-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATAWIDTH-1:0] out_data_o,
    output logic                 out_last_o,
    output logic                 busy_o
);

    localparam int CW         = $clog2(N);
    localparam int SW         = $clog2(N / 2 + 1);
    localparam int EVEN_PAIRS = N / 2;
    localparam int ODD_PAIRS  = N / 2 - 1;

    topk_seq_state_e      state;
    logic [DATAWIDTH-1:0] mem [N];
    logic [CW-1:0]        load_cnt;
    logic [CW-1:0]        drain_cnt;
    logic [CW-1:0]        phase;
    logic [SW-1:0]        slot;
    logic                 sign_q;

    logic [SW-1:0]        phase_pairs;
    logic                 issue;
    logic [CW-1:0]        rd_idx;
    logic [CW-1:0]        rd_idx_hi;
    logic                 wb_valid;
    logic [CW-1:0]        wb_idx;
    logic [CW-1:0]        wb_idx_hi;
    logic [CW-1:0]        out_idx;
    logic                 early_done;

    ctrl_t                cas_ctrl;
    logic [DATAWIDTH-1:0] cas_y1;
    logic [DATAWIDTH-1:0] cas_y2;

    // Pair scheduling: even phases start at index 0, odd phases at 1; the slot
    // after the last pair of a phase is the bubble that lets the writeback land
    always_comb begin
        phase_pairs = phase[0] ? SW'(ODD_PAIRS) : SW'(EVEN_PAIRS);
        issue       = (state == ST_SORT) && (slot < phase_pairs);
        rd_idx      = CW'(2 * int'(slot) + int'(phase[0]));
        rd_idx_hi   = rd_idx + CW'(1);
        wb_idx_hi   = wb_idx + CW'(1);
        out_idx     = CW'(N - 1) - drain_cnt;
        cas_ctrl           = CTRL_IDLE;
        cas_ctrl.sign_ctrl = sign_q;
    end

    assign out_data_o = out_valid_o ? mem[out_idx] : '0;
    assign out_last_o = out_valid_o && (drain_cnt == CW'(K - 1));

    cas #(
        .DATAWIDTH(DATAWIDTH)
    ) u_cas (
        .clk   (clk_i),
        .rst_n (~rst_i),
        .ctrl  (cas_ctrl),
        .x1    (mem[rd_idx]),
        .x2    (mem[rd_idx_hi]),
        .y1    (cas_y1),
        .y2    (cas_y2)
    );

`ifdef TOPK_SEQ_EARLY_EXIT_EN
    logic swap_seen;
    logic prev_clean;
    logic swap_now;
    logic phase_dirty;

    assign swap_now    = wb_valid && (cas_y1 != mem[wb_idx]);
    assign phase_dirty = swap_seen || swap_now;
    assign early_done  = prev_clean && !phase_dirty;

    // Track swaps within the current phase and whether the previous phase was clean
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            swap_seen  <= 1'b0;
            prev_clean <= 1'b0;
        end else if (state != ST_SORT) begin
            swap_seen  <= 1'b0;
            prev_clean <= 1'b0;
        end else if (!issue) begin
            swap_seen  <= 1'b0;
            prev_clean <= !phase_dirty;
        end else if (swap_now) begin
            swap_seen  <= 1'b1;
        end
    end
`else
    assign early_done = 1'b0;
`endif

    // Element buffer: loads in LOAD, cas writeback to the issuing pair in SORT
    always_ff @(posedge clk_i) begin
        if (state == ST_LOAD && in_valid_i) begin
            mem[load_cnt] <= in_data_i;
        end else if (wb_valid) begin
            mem[wb_idx]    <= cas_y1;
            mem[wb_idx_hi] <= cas_y2;
        end
    end

    // Controller FSM with registered handshake/status outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_LOAD;
            load_cnt    <= '0;
            drain_cnt   <= '0;
            phase       <= '0;
            slot        <= '0;
            sign_q      <= 1'b0;
            wb_valid    <= 1'b0;
            wb_idx      <= '0;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            wb_valid <= issue;
            wb_idx   <= rd_idx;
            unique case (state)
                ST_LOAD: begin
                    if (in_valid_i) begin
                        if (load_cnt == '0) begin
                            sign_q <= sign_i;
                        end
                        if (load_cnt == CW'(N - 1)) begin
                            load_cnt   <= '0;
                            phase      <= '0;
                            slot       <= '0;
                            in_ready_o <= 1'b0;
                            busy_o     <= 1'b1;
                            state      <= ST_SORT;
                        end else begin
                            load_cnt <= load_cnt + CW'(1);
                        end
                    end
                end
                ST_SORT: begin
                    if (issue) begin
                        slot <= slot + SW'(1);
                    end else begin
                        slot <= '0;
                        if (phase == CW'(N - 1) || early_done) begin
                            phase       <= '0;
                            drain_cnt   <= '0;
                            out_valid_o <= 1'b1;
                            state       <= ST_DRAIN;
                        end else begin
                            phase <= phase + CW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_ready_i) begin
                        if (drain_cnt == CW'(K - 1)) begin
                            drain_cnt   <= '0;
                            out_valid_o <= 1'b0;
                            busy_o      <= 1'b0;
                            in_ready_o  <= 1'b1;
                            state       <= ST_LOAD;
                        end else begin
                            drain_cnt <= drain_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_topk_seq_ctrl.sv
// Directed bench for topk_seq_ctrl (N=8, K=4, 8-bit) with a queue scoreboard.
// Honours TOPK_SEQ_EARLY_EXIT_EN for the expected sort length.
module tb_topk_seq_ctrl;

    localparam int N = 8;
    localparam int K = 4;
`ifdef TOPK_SEQ_EARLY_EXIT_EN
    localparam int FULL_SORT = -1;
    localparam int ASC_SORT  = 9;
`else
    localparam int FULL_SORT = 36;
    localparam int ASC_SORT  = 36;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sign = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] batch [N];
    logic [7:0] expect_vals [K];
    logic [7:0] exp_q [$];

    topk_seq_ctrl #(
        .DATAWIDTH(8),
        .N(N),
        .K(K)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sign_i      (sign),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .busy_o      (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference top-K by repeated selection of the largest remaining element
    task automatic modelTopk(input logic s);
        logic used [N];
        int   best;
        logic better;
        for (int i = 0; i < N; i++) used[i] = 1'b0;
        for (int k = 0; k < K; k++) begin
            best = -1;
            for (int i = 0; i < N; i++) begin
                if (!used[i]) begin
                    if (best < 0) better = 1'b1;
                    else if (s)   better = $signed(batch[i]) > $signed(batch[best]);
                    else          better = batch[i] > batch[best];
                    if (better) best = i;
                end
            end
            used[best]     = 1'b1;
            expect_vals[k] = batch[best];
        end
    endtask

    // Load one batch; ends on the first negedge of SORT
    task automatic applyStimulus(input logic s, input logic push, input logic hold_valid);
        if (push) begin
            for (int i = 0; i < K; i++) exp_q.push_back(expect_vals[i]);
        end
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            checkOutput("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            in_data  = batch[i];
            sign     = s;
        end
        @(negedge clk);
        checkOutput("in_ready_sort_entry", in_ready, 0);
        checkOutput("busy_sort_entry", busy, 1);
        if (hold_valid) begin
            in_data = 8'hEE;
            sign    = ~s;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // Count SORT cycles until out_valid rises
    task automatic waitSort(input int exp_cycles);
        int cycles = 0;
        while (!out_valid && cycles < 200) begin
            checkOutput("in_ready_busy", in_ready, 0);
            cycles++;
            @(negedge clk);
        end
        checkOutput("drain_reached", out_valid, 1);
        if (exp_cycles >= 0) checkOutput("sort_cycles", cycles, exp_cycles);
        else                 checkOutput("sort_cycles_max", cycles <= 36, 1);
    endtask

    // Pop and compare every beat, optionally stalling one of them
    task automatic drainBatch(input int stall_beat);
        logic [7:0] exp;
        for (int b = 0; b < K; b++) begin
            exp = exp_q.pop_front();
            checkOutput("out_valid", out_valid, 1);
            checkOutput("out_data", out_data, exp);
            checkOutput("out_last", out_last, b == K - 1);
            if (b == stall_beat) begin
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("stall_data", out_data, exp);
                    checkOutput("stall_valid", out_valid, 1);
                end
                out_ready = 1'b1;
            end
            if (b == K - 1) in_valid = 1'b0;
            @(negedge clk);
        end
        checkOutput("in_ready_after", in_ready, 1);
        checkOutput("out_valid_after", out_valid, 0);
        checkOutput("busy_after", busy, 0);
        checkOutput("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_data", out_data, 0);

        // Unsigned batch, in_valid held high with junk during SORT/DRAIN
        batch       = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd0, 8'd255, 8'd4, 8'd7};
        expect_vals = '{8'd255, 8'd9, 8'd7, 8'd7};
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitSort(FULL_SORT);
        drainBatch(-1);

        // Signed batch with backpressure on beat 2
        batch       = '{8'h80, 8'h7F, 8'hFF, 8'h01, 8'h00, 8'h05, 8'hFE, 8'h10};
        expect_vals = '{8'h7F, 8'h10, 8'h05, 8'h01};
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitSort(FULL_SORT);
        drainBatch(1);

        // Same data compared unsigned
        expect_vals = '{8'hFF, 8'hFE, 8'h80, 8'h7F};
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitSort(FULL_SORT);
        drainBatch(-1);

        // Already ascending input
        batch       = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        expect_vals = '{8'd7, 8'd6, 8'd5, 8'd4};
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitSort(ASC_SORT);
        drainBatch(-1);

        // Reset 10 cycles into SORT
        batch = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_out_last", out_last, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_out_data", out_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_in_ready", in_ready, 1);

        // Fresh batch after the abort
        batch       = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        expect_vals = '{8'd8, 8'd7, 8'd6, 8'd5};
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitSort(FULL_SORT);
        drainBatch(-1);

        // Random batches with duplicates, checked against the selection model
        for (int r = 0; r < 3; r++) begin
            logic s;
            s = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) batch[i] = 8'($urandom_range(0, 15)) ^ (s ? 8'hF8 : 8'h00);
            modelTopk(s);
            applyStimulus(s, 1'b1, 1'b0);
            waitSort(FULL_SORT);
            drainBatch(r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
